// File: rtl/el2_ifu_rvc_align_expand.sv
// Fetch-beat aligner and RVC expander: buffers halfwords, picks one RV32
// instruction per cycle off the head, expands 16b encodings to 32b.
module el2_ifu_rvc_align_expand #(
  parameter int FETCH_HW = 2,
  parameter int QDEPTH   = 6,
  parameter bit RVC_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [16*FETCH_HW-1:0] fetch_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic                  inst_is16,
  output logic                  inst_illegal
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [15:0]   q [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [15:0]   h0, h1;
  logic          head32, have, out_en, load, push;
  logic [1:0]    pop_n;
  logic [32:0]   exp16;

  // circular pointer advance; p < QDEPTH and n <= QDEPTH so one wrap suffices
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= QDEPTH) s = s - QDEPTH;
    return s[PW-1:0];
  endfunction

  // RV32C -> RV32I expansion; returns {illegal, inst}, inst forced to 0 when illegal
  function automatic logic [32:0] rvc_expand(input logic [15:0] c);
    logic [31:0] i;
    logic        ill;
    logic [4:0]  rd, rs2, rs1p, rs2p;
    i    = '0;
    ill  = 1'b0;
    rd   = c[11:7];
    rs2  = c[6:2];
    rs1p = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};
    case (c[1:0])
      2'b00: case (c[15:13])
        3'b000: begin  // c.addi4spn
          i   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, 7'h13};
          ill = (c[12:5] == 8'h00);
        end
        3'b010: i = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rs2p, 7'h03};
        3'b110: i = {5'b0, c[5], c[12], rs2p, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
        default: ill = 1'b1;  // FP loads/stores and reserved
      endcase
      2'b01: case (c[15:13])
        3'b000: i = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
        3'b001: i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                     {9{c[12]}}, 5'd1, 7'h6f};
        3'b010: i = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
        3'b011: begin
          ill = ({c[12], c[6:2]} == 6'd0);
          if (rd == 5'd2)
            i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
          else
            i = {{15{c[12]}}, c[6:2], rd, 7'h37};
        end
        3'b100: case (c[11:10])
          2'b00: begin i = {7'b0, c[6:2], rs1p, 3'b101, rs1p, 7'h13}; ill = c[12]; end
          2'b01: begin i = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13}; ill = c[12]; end
          2'b10: i = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'h13};
          default: begin
            ill = c[12];  // RV64-only subw/addw and reserved
            case (c[6:5])
              2'b00:   i = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, 7'h33};
              2'b01:   i = {7'b0, rs2p, rs1p, 3'b100, rs1p, 7'h33};
              2'b10:   i = {7'b0, rs2p, rs1p, 3'b110, rs1p, 7'h33};
              default: i = {7'b0, rs2p, rs1p, 3'b111, rs1p, 7'h33};
            endcase
          end
        endcase
        3'b101: i = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                     {9{c[12]}}, 5'd0, 7'h6f};
        3'b110: i = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10], c[4:3], c[12], 7'h63};
        default: i = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10], c[4:3], c[12], 7'h63};
      endcase
      2'b10: case (c[15:13])
        3'b000: begin i = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13}; ill = c[12]; end
        3'b010: begin
          i   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
          ill = (rd == 5'd0);
        end
        3'b100: begin
          if (!c[12]) begin
            if (rs2 == 5'd0) begin i = {12'b0, rd, 3'b000, 5'd0, 7'h67}; ill = (rd == 5'd0); end
            else i = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
          end else if (rs2 == 5'd0) begin
            if (rd == 5'd0) i = 32'h0010_0073;
            else            i = {12'b0, rd, 3'b000, 5'd1, 7'h67};
          end else
            i = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
        end
        3'b110: i = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
        default: ill = 1'b1;
      endcase
      default: ill = 1'b1;  // 32b encoding, never routed here
    endcase
    if (!RVC_EN) ill = 1'b1;
    if (ill) i = '0;
    return {ill, i};
  endfunction

  assign fetch_ready = (count <= CW'(QDEPTH - FETCH_HW));
  assign push        = fetch_valid && fetch_ready && !flush;

  // head decode and pop/credit bookkeeping
  always_comb begin
    h0        = q[rd_ptr];
    h1        = q[ptr_add(rd_ptr, 1)];
    head32    = (h0[1:0] == 2'b11);
    have      = head32 ? (count >= CW'(2)) : (count != '0);
    out_en    = !inst_valid || inst_ready;
    load      = out_en && have && !flush;
    pop_n     = load ? (head32 ? 2'd2 : 2'd1) : 2'd0;
    count_nxt = count + (push ? CW'(FETCH_HW) : '0) - CW'(pop_n);
    exp16     = rvc_expand(h0);
  end

  // halfword storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push)
      for (int i = 0; i < FETCH_HW; i++)
        q[ptr_add(wr_ptr, i)] <= fetch_data[16*i +: 16];
  end

  // queue pointers and occupancy; flush empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_add(wr_ptr, FETCH_HW);
      if (load) rd_ptr <= ptr_add(rd_ptr, pop_n);
      count <= count_nxt;
    end
  end

  // output register; holds steady while stalled, drops valid on a straddle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid   <= 1'b0;
      inst         <= '0;
      inst_is16    <= 1'b0;
      inst_illegal <= 1'b0;
    end else if (flush) begin
      inst_valid   <= 1'b0;
      inst         <= '0;
      inst_is16    <= 1'b0;
      inst_illegal <= 1'b0;
    end else if (out_en) begin
      inst_valid <= have;
      if (have) begin
        if (head32) begin
          inst         <= {h1, h0};
          inst_is16    <= 1'b0;
          inst_illegal <= 1'b0;
        end else begin
          inst         <= exp16[31:0];
          inst_is16    <= 1'b1;
          inst_illegal <= exp16[32];
        end
      end
    end
  end

endmodule
